// File: rtl/pipeline_sequencer.sv
// pipeline_sequencer: run/step/stop/halt sequencing of the 5-stage pipeline enables and flushes.
// Performance counters are built only when PIPE_SEQ_PERF_CNT_EN is defined.
module pipeline_sequencer #(
  parameter int DRAIN_CYCLES = 3,
  parameter int CNT_WIDTH    = 32
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_run,
  input  logic                 i_step,
  input  logic                 i_stop,
  input  logic                 i_stall,
  input  logic                 i_branch_taken,
  input  logic                 i_halt_decoded,
  output logic                 o_pc_en,
  output logic                 o_if_id_en,
  output logic                 o_if_id_flush,
  output logic                 o_id_ex_flush,
  output logic                 o_back_en,
  output logic                 o_running,
  output logic                 o_halted,
  output logic                 o_done,
  output logic [CNT_WIDTH-1:0] o_cycle_count,
  output logic [CNT_WIDTH-1:0] o_stall_count
);

  localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [DW-1:0] DRAIN_LOAD = DW'(DRAIN_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, RUN, STEP, DRAIN, HALTED} state_t;

  state_t        state, next_state;
  logic [DW-1:0] drain_cnt, drain_cnt_next;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state     <= IDLE;
      drain_cnt <= '0;
    end else begin
      state     <= next_state;
      drain_cnt <= drain_cnt_next;
    end
  end

  always_comb begin
    next_state     = state;
    drain_cnt_next = drain_cnt;
    o_pc_en        = 1'b0;
    o_if_id_en     = 1'b0;
    o_if_id_flush  = 1'b0;
    o_id_ex_flush  = 1'b0;
    o_back_en      = 1'b0;
    o_halted       = 1'b0;
    o_done         = 1'b0;
    o_running      = (state == RUN);

    case (state)
      IDLE: begin
        if (i_run)       next_state = RUN;
        else if (i_step) next_state = STEP;
      end
      RUN, STEP: begin
        o_back_en = 1'b1;
        if (i_stall) begin
          o_id_ex_flush = 1'b1;
        end else begin
          o_if_id_en    = 1'b1;
          o_pc_en       = !i_halt_decoded;
          o_if_id_flush = i_halt_decoded | i_branch_taken;
        end
        // An accepted HALT takes priority over stop and the end of a step
        if (!i_stall && i_halt_decoded) begin
          next_state     = DRAIN;
          drain_cnt_next = DRAIN_LOAD;
        end else if (state == STEP || i_stop) begin
          next_state = IDLE;
        end else begin
          next_state = RUN;
        end
      end
      DRAIN: begin
        o_if_id_en    = 1'b1;
        o_if_id_flush = 1'b1;
        o_back_en     = 1'b1;
        if (drain_cnt == '0) begin
          next_state = HALTED;
          o_done     = 1'b1;
        end else begin
          drain_cnt_next = drain_cnt - 1'b1;
        end
      end
      HALTED: o_halted = 1'b1;
      default: next_state = IDLE;
    endcase
  end

`ifdef PIPE_SEQ_PERF_CNT_EN
  logic                 adv, stall_adv;
  logic [CNT_WIDTH-1:0] cycle_count, stall_count;

  assign adv       = (state == RUN) || (state == STEP) || (state == DRAIN);
  assign stall_adv = ((state == RUN) || (state == STEP)) && i_stall;

  // Saturating counters; they hold whenever the pipeline is frozen
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      cycle_count <= '0;
      stall_count <= '0;
    end else begin
      if (adv && cycle_count != '1)       cycle_count <= cycle_count + 1'b1;
      if (stall_adv && stall_count != '1) stall_count <= stall_count + 1'b1;
    end
  end

  assign o_cycle_count = cycle_count;
  assign o_stall_count = stall_count;
`else
  assign o_cycle_count = '0;
  assign o_stall_count = '0;
`endif

endmodule

// File: tb/tb_pipeline_sequencer.sv
// Self-checking bench for pipeline_sequencer: directed scenarios plus randomized traffic
// compared against a mode-level reference model.
module tb_pipeline_sequencer;

  localparam int DRAIN_CYCLES = 3;
  localparam int CNT_WIDTH    = 32;
`ifdef PIPE_SEQ_PERF_CNT_EN
  localparam int PERF = 1;
`else
  localparam int PERF = 0;
`endif

  logic clock = 1'b0;
  logic reset, run, step, stop, stall, branch, halt;
  logic pc_en, if_id_en, if_id_flush, id_ex_flush, back_en, running, halted, done;
  logic [CNT_WIDTH-1:0] cycle_count, stall_count;
  logic [7:0] obs_ctrl;

  int checks = 0;
  int passes = 0;

  typedef enum int {M_IDLE, M_RUN, M_STEP, M_DRAIN, M_HALTED} mode_t;
  mode_t  m_mode = M_IDLE;
  int     m_left = 0;
  longint m_cyc  = 0;
  longint m_stl  = 0;

  always #5 clock = ~clock;

  pipeline_sequencer #(
    .DRAIN_CYCLES(DRAIN_CYCLES),
    .CNT_WIDTH   (CNT_WIDTH)
  ) dut (
    .i_clk         (clock),
    .i_reset       (reset),
    .i_run         (run),
    .i_step        (step),
    .i_stop        (stop),
    .i_stall       (stall),
    .i_branch_taken(branch),
    .i_halt_decoded(halt),
    .o_pc_en       (pc_en),
    .o_if_id_en    (if_id_en),
    .o_if_id_flush (if_id_flush),
    .o_id_ex_flush (id_ex_flush),
    .o_back_en     (back_en),
    .o_running     (running),
    .o_halted      (halted),
    .o_done        (done),
    .o_cycle_count (cycle_count),
    .o_stall_count (stall_count)
  );

  assign obs_ctrl = {pc_en, if_id_en, if_id_flush, id_ex_flush, back_en, running, halted, done};

  // Reference model: tracks the sequencer mode, remaining drain cycles and raw event counts
  always @(posedge clock) begin
    if (reset) begin
      m_mode = M_IDLE;
      m_left = 0;
      m_cyc  = 0;
      m_stl  = 0;
    end else begin
      case (m_mode)
        M_IDLE: begin
          if (run)       m_mode = M_RUN;
          else if (step) m_mode = M_STEP;
        end
        M_RUN, M_STEP: begin
          m_cyc++;
          if (stall) m_stl++;
          if (!stall && halt) begin
            m_mode = M_DRAIN;
            m_left = DRAIN_CYCLES;
          end else if (m_mode == M_STEP || stop) begin
            m_mode = M_IDLE;
          end
        end
        M_DRAIN: begin
          m_cyc++;
          m_left--;
          if (m_left == 0) m_mode = M_HALTED;
        end
        default: ;
      endcase
    end
  end

  // {pc_en, if_id_en, if_id_flush, id_ex_flush, back_en, running, halted, done}
  function automatic logic [7:0] expect_ctrl();
    logic [7:0] e;
    e = 8'b0000_0000;
    case (m_mode)
      M_RUN, M_STEP: begin
        if (stall)     e = 8'b0001_1000;
        else if (halt) e = 8'b0110_1000;
        else           e = {1'b1, 1'b1, branch, 1'b0, 1'b1, 3'b000};
        e[2] = (m_mode == M_RUN);
      end
      M_DRAIN:  e = {7'b0110_100, (m_left == 1)};
      M_HALTED: e = 8'b0000_0010;
      default:  e = 8'b0000_0000;
    endcase
    return e;
  endfunction

  function automatic logic [CNT_WIDTH-1:0] expect_count(input longint n);
    logic [CNT_WIDTH-1:0] r;
    longint maxv;
    maxv = (longint'(1) << CNT_WIDTH) - 1;
    r = (n > maxv) ? '1 : n[CNT_WIDTH-1:0];
    if (PERF == 0) r = '0;
    return r;
  endfunction

  task automatic set_in(input logic r, s, sp, sl, b, h, rs);
    @(negedge clock);
    run = r; step = s; stop = sp; stall = sl; branch = b; halt = h; reset = rs;
    #1;
  endtask

  task automatic do_reset();
    set_in(0, 0, 0, 0, 0, 0, 1);
  endtask

  task automatic test_reset();
    do_reset();
    do_reset();
    set_in(1, 1, 0, 0, 0, 0, 0);
    checks++;
    if (obs_ctrl !== 8'h00) $display("[TB] FAIL reset_ctrl: got %b expected %b", obs_ctrl, 8'h00);
    else passes++;
    checks++;
    if (cycle_count !== '0 || stall_count !== '0)
      $display("[TB] FAIL reset_counters: got %0d/%0d expected 0/0", cycle_count, stall_count);
    else passes++;
  endtask

  task automatic test_step();
    int pulses;
    pulses = 0;
    do_reset();
    for (int k = 0; k < 3; k++) begin
      set_in(0, 1, 0, 0, 0, 0, 0);
      if (pc_en === 1'b1) pulses++;
      for (int j = 0; j < 3; j++) begin
        set_in(0, 0, 0, 0, 0, 0, 0);
        if (pc_en === 1'b1) pulses++;
        checks++;
        if (obs_ctrl !== expect_ctrl())
          $display("[TB] FAIL step_ctrl: got %b expected %b", obs_ctrl, expect_ctrl());
        else passes++;
      end
    end
    checks++;
    if (pulses !== 3) $display("[TB] FAIL step_pulses: got %0d expected 3", pulses);
    else passes++;
    checks++;
    if (cycle_count !== CNT_WIDTH'(3 * PERF))
      $display("[TB] FAIL step_cycle_count: got %0d expected %0d", cycle_count, 3 * PERF);
    else passes++;
  endtask

  task automatic test_stall();
    do_reset();
    set_in(1, 0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 2; k++) begin
      set_in(0, 0, 0, 1, 0, 0, 0);
      checks++;
      if (obs_ctrl !== 8'b0001_1100) $display("[TB] FAIL stall_ctrl: got %b expected %b", obs_ctrl, 8'b0001_1100);
      else passes++;
    end
    set_in(0, 0, 0, 0, 0, 0, 0);
    checks++;
    if (stall_count !== CNT_WIDTH'(2 * PERF))
      $display("[TB] FAIL stall_count: got %0d expected %0d", stall_count, 2 * PERF);
    else passes++;
  endtask

  task automatic test_branch();
    do_reset();
    set_in(1, 0, 0, 0, 0, 0, 0);
    set_in(0, 0, 0, 1, 1, 0, 0);
    checks++;
    if (if_id_flush !== 1'b0) $display("[TB] FAIL branch_under_stall: got %b expected 0", if_id_flush);
    else passes++;
    set_in(0, 0, 0, 0, 1, 0, 0);
    checks++;
    if (obs_ctrl !== 8'b1110_1100) $display("[TB] FAIL branch_flush: got %b expected %b", obs_ctrl, 8'b1110_1100);
    else passes++;
  endtask

  task automatic test_halt();
    int dones;
    dones = 0;
    do_reset();
    set_in(1, 0, 0, 0, 0, 0, 0);
    set_in(0, 0, 0, 0, 0, 1, 0);
    checks++;
    if (obs_ctrl !== 8'b0110_1100) $display("[TB] FAIL halt_issue: got %b expected %b", obs_ctrl, 8'b0110_1100);
    else passes++;
    for (int k = 0; k < DRAIN_CYCLES; k++) begin
      set_in(1, 1, 1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1, 0);
      if (done === 1'b1) dones++;
      checks++;
      if (obs_ctrl !== {7'b0110_100, (k == DRAIN_CYCLES - 1)})
        $display("[TB] FAIL drain_ctrl: got %b expected %b", obs_ctrl, {7'b0110_100, (k == DRAIN_CYCLES - 1)});
      else passes++;
    end
    for (int k = 0; k < 4; k++) begin
      set_in(1, 0, 0, 0, 0, 0, 0);
      if (done === 1'b1) dones++;
      checks++;
      if (obs_ctrl !== 8'b0000_0010) $display("[TB] FAIL halted_ctrl: got %b expected %b", obs_ctrl, 8'b0000_0010);
      else passes++;
    end
    checks++;
    if (dones !== 1) $display("[TB] FAIL done_pulses: got %0d expected 1", dones);
    else passes++;
  endtask

  task automatic test_run_step();
    do_reset();
    set_in(1, 1, 0, 0, 0, 0, 0);
    set_in(0, 0, 0, 0, 0, 0, 0);
    checks++;
    if (running !== 1'b1) $display("[TB] FAIL run_step_priority: got %b expected 1", running);
    else passes++;
    set_in(0, 0, 1, 0, 0, 0, 0);
    checks++;
    if (pc_en !== 1'b1) $display("[TB] FAIL stop_cycle_advance: got %b expected 1", pc_en);
    else passes++;
    set_in(0, 0, 0, 0, 0, 0, 0);
    checks++;
    if (obs_ctrl !== 8'h00) $display("[TB] FAIL stop_to_idle: got %b expected %b", obs_ctrl, 8'h00);
    else passes++;
  endtask

  task automatic test_reset_drain();
    int dones;
    dones = 0;
    do_reset();
    set_in(1, 0, 0, 0, 0, 0, 0);
    set_in(0, 0, 0, 0, 0, 1, 0);
    set_in(0, 0, 0, 0, 0, 0, 1);
    if (done === 1'b1) dones++;
    for (int k = 0; k < DRAIN_CYCLES + 1; k++) begin
      set_in(0, 0, 0, 0, 0, 0, 0);
      if (done === 1'b1) dones++;
    end
    checks++;
    if (obs_ctrl !== 8'h00) $display("[TB] FAIL reset_drain_ctrl: got %b expected %b", obs_ctrl, 8'h00);
    else passes++;
    checks++;
    if (dones !== 0) $display("[TB] FAIL reset_drain_done: got %0d expected 0", dones);
    else passes++;
    checks++;
    if (cycle_count !== '0 || stall_count !== '0)
      $display("[TB] FAIL reset_drain_counters: got %0d/%0d expected 0/0", cycle_count, stall_count);
    else passes++;
  endtask

  task automatic test_random();
    logic rs;
    do_reset();
    for (int k = 0; k < 400; k++) begin
      rs = ($urandom_range(0, 39) == 0) || (m_mode == M_HALTED && $urandom_range(0, 5) == 0);
      set_in($urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 5) == 0,
             $urandom_range(0, 2) == 0, $urandom_range(0, 1) == 0, $urandom_range(0, 11) == 0, rs);
      checks++;
      if (obs_ctrl !== expect_ctrl())
        $display("[TB] FAIL random_ctrl: got %b expected %b at iter %0d", obs_ctrl, expect_ctrl(), k);
      else passes++;
      checks++;
      if (cycle_count !== expect_count(m_cyc) || stall_count !== expect_count(m_stl))
        $display("[TB] FAIL random_counters: got %0d/%0d expected %0d/%0d at iter %0d",
                 cycle_count, stall_count, expect_count(m_cyc), expect_count(m_stl), k);
      else passes++;
    end
  endtask

  initial begin
    reset = 1'b1; run = 1'b0; step = 1'b0; stop = 1'b0;
    stall = 1'b0; branch = 1'b0; halt = 1'b0;
    test_reset();
    test_step();
    test_stall();
    test_branch();
    test_halt();
    test_run_step();
    test_reset_drain();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
